// File: rtl/front_panel_cursor.sv
// front_panel_cursor
//
// Turns raw joystick/keyboard inputs into the cursor controls used by front_panel.
// Each raw input is synchronised with two flops and then debounced. A held direction
// auto-repeats. The cursor wraps within a two-row switch grid, and the two rows may
// have different lengths.
//
// Ports:
//   clk             system clock
//   reset           asynchronous, active-high reset
//   joy_up/down/left/right/fire
//                   raw, asynchronous inputs
//   cursor_index_x  selected column
//   cursor_index_y  selected row (0 or 1; the upper bits are always 0)
//   cursor_action   debounced fire level
//   cursor_moved    one-cycle pulse whenever (x,y) changes

module front_panel_cursor #(
    parameter int unsigned ROW0_COLS       = 16,
    parameter int unsigned ROW1_COLS       = 9,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 20000000,
    parameter int unsigned REPEAT_RATE     = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       joy_up,
    input  logic       joy_down,
    input  logic       joy_left,
    input  logic       joy_right,
    input  logic       joy_fire,
    output logic [3:0] cursor_index_x,
    output logic [4:0] cursor_index_y,
    output logic       cursor_action,
    output logic       cursor_moved
);

    localparam int unsigned DebW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RepW   = (RepMax > 1) ? $clog2(RepMax) : 1;

    localparam logic [DebW-1:0] DebLast   = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RepW-1:0] DelayLoad = RepW'(REPEAT_DELAY - 1);
    localparam logic [RepW-1:0] RateLoad  = RepW'(REPEAT_RATE - 1);
    localparam logic [3:0]      Row0Last  = 4'(ROW0_COLS - 1);
    localparam logic [3:0]      Row1Last  = 4'(ROW1_COLS - 1);

    // Bit positions of the inputs within the raw, synchronised and debounced vectors.
    localparam int unsigned IdxFire  = 0;
    localparam int unsigned IdxRight = 1;
    localparam int unsigned IdxLeft  = 2;
    localparam int unsigned IdxDown  = 3;
    localparam int unsigned IdxUp    = 4;

    typedef enum logic [2:0] {DirNone, DirUp, DirDown, DirLeft, DirRight} dir_e;
    typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

    logic [4:0]            raw;
    logic [4:0]            sync1_q, sync2_q;
    logic [4:0]            deb_q, deb_d;
    logic [4:0][DebW-1:0]  deb_cnt_q, deb_cnt_d;

    state_e                state_q, state_d;
    dir_e                  dir_latch_q, dir_latch_d;
    logic [RepW-1:0]       rep_cnt_q, rep_cnt_d;

    logic [3:0]            x_q, x_d;
    logic                  y_q, y_d;
    logic                  moved_q, moved_d;

    dir_e                  dir;
    logic                  step;
    logic                  up_only, down_only, left_only, right_only;
    logic [3:0]            cur_last, alt_last;
    logic [3:0]            nx;
    logic                  ny;

    always_comb begin
        raw = {joy_up, joy_down, joy_left, joy_right, joy_fire};
    end

    // Debounce: an input change is accepted only after it has stayed stable for
    // DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < 5; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DebLast) begin
                deb_d[i]     = sync2_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DebW'(1);
            end
        end
    end

    // Direction resolution. Opposing directions cancel each other. A held fire
    // suppresses all movement, so the switch being operated cannot shift.
    always_comb begin
        up_only    = deb_q[IdxUp] & ~deb_q[IdxDown];
        down_only  = deb_q[IdxDown] & ~deb_q[IdxUp];
        left_only  = deb_q[IdxLeft] & ~deb_q[IdxRight];
        right_only = deb_q[IdxRight] & ~deb_q[IdxLeft];
        dir        = DirNone;
        if (!deb_q[IdxFire]) begin
            if (up_only) begin
                dir = DirUp;
            end else if (down_only) begin
                dir = DirDown;
            end else if (left_only) begin
                dir = DirLeft;
            end else if (right_only) begin
                dir = DirRight;
            end
        end
    end

    // Auto-repeat FSM. Every step moves in the current direction. A step caused by
    // a direction change therefore uses the new direction.
    always_comb begin
        state_d     = state_q;
        dir_latch_d = dir_latch_q;
        rep_cnt_d   = rep_cnt_q;
        step        = 1'b0;
        case (state_q)
            StIdle: begin
                if (dir != DirNone) begin
                    step        = 1'b1;
                    dir_latch_d = dir;
                    rep_cnt_d   = DelayLoad;
                    state_d     = StHold;
                end
            end
            StHold, StRepeat: begin
                if (dir == DirNone) begin
                    state_d = StIdle;
                end else if (dir != dir_latch_q) begin
                    step        = 1'b1;
                    dir_latch_d = dir;
                    rep_cnt_d   = DelayLoad;
                    state_d     = StHold;
                end else if (rep_cnt_q == '0) begin
                    step      = 1'b1;
                    rep_cnt_d = RateLoad;
                    state_d   = StRepeat;
                end else begin
                    rep_cnt_d = rep_cnt_q - RepW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Step arithmetic. After a vertical move, x is clamped to the last column of the
    // row the cursor lands on.
    always_comb begin
        cur_last = y_q ? Row1Last : Row0Last;
        alt_last = y_q ? Row0Last : Row1Last;
        nx       = x_q;
        ny       = y_q;
        case (dir)
            DirRight: nx = (x_q == cur_last) ? 4'd0 : x_q + 4'd1;
            DirLeft:  nx = (x_q == 4'd0) ? cur_last : x_q - 4'd1;
            DirUp, DirDown: begin
                ny = ~y_q;
                nx = (x_q > alt_last) ? alt_last : x_q;
            end
            default: ;
        endcase
        x_d     = x_q;
        y_d     = y_q;
        moved_d = 1'b0;
        if (step) begin
            x_d     = nx;
            y_d     = ny;
            moved_d = (nx != x_q) || (ny != y_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            deb_cnt_q   <= '0;
            state_q     <= StIdle;
            dir_latch_q <= DirNone;
            rep_cnt_q   <= '0;
            x_q         <= '0;
            y_q         <= 1'b0;
            moved_q     <= 1'b0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            deb_cnt_q   <= deb_cnt_d;
            state_q     <= state_d;
            dir_latch_q <= dir_latch_d;
            rep_cnt_q   <= rep_cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            moved_q     <= moved_d;
        end
    end

    always_comb begin
        cursor_index_x = x_q;
        cursor_index_y = {4'b0000, y_q};
        cursor_action  = deb_q[IdxFire];
        cursor_moved   = moved_q;
    end

endmodule
